// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM states, byte-lane geometry and the
// fault-cause classification applied to a latched request.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

  localparam int LANE_W         = 2;
  localparam int BYTES_PER_WORD = 4;

  // Debug encoding of why an access was rejected; FC_NONE means the access commits.
  typedef enum logic [1:0] {FC_NONE, FC_RW_BOTH, FC_MISALIGN, FC_RANGE} fault_cause_t;

  function automatic fault_cause_t classify(input logic rd, input logic wr, input logic byte_acc,
                                            input logic [31:0] addr, input int depth);
    if (rd && wr)                                   return FC_RW_BOTH;
    if (!byte_acc && addr[LANE_W-1:0] != '0)        return FC_MISALIGN;
    if (addr >= 32'(depth * BYTES_PER_WORD))        return FC_RANGE;
    return FC_NONE;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous RAM, DEPTH x 32, per-byte write enable and registered read.
// Each byte lane is its own array so byte writes never touch neighbouring lanes.
module data_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (be[gi]) lane_mem[addr] <= wdata[gi*8 +: 8];
        q_reg <= lane_mem[addr];
      end

      assign rdata[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the DataPath load/store port: latches a request, inserts LATENCY
// wait states while stalling the CPU, then commits to data_ram and presents the result for one cycle.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        byte_acc,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  mem_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      read_data_reg;
  logic             byte_reg;
  logic             rd_reg;
  logic             wr_reg;
  logic             fault_reg;

  logic             req;
  logic             commit;
  fault_cause_t     cause;
  logic [1:0]       lane;
  logic [IDX_W-1:0] ram_addr;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;
  logic [31:0]      lane_data;

  assign req    = mem_read | mem_write;
  assign cause  = classify(rd_reg, wr_reg, byte_reg, addr_reg, DEPTH);
  assign commit = (state_reg == BUSY) && req && (cnt_reg == '0);
  assign lane   = addr_reg[1:0];

  // The RAM is addressed from the live bus while IDLE so its registered read is already
  // valid during BUSY; this keeps a zero-wait-state access possible.
  assign ram_addr = (state_reg == IDLE) ? addr[IDX_W+1:2] : addr_reg[IDX_W+1:2];

  always_comb begin
    ram_be    = '0;
    ram_wdata = byte_reg ? {4{wdata_reg[7:0]}} : wdata_reg;
    if (commit && wr_reg && cause == FC_NONE)
      ram_be = byte_reg ? (4'b0001 << lane) : 4'b1111;
  end

  assign lane_data = byte_reg ? {24'b0, ram_rdata[{lane, 3'b000} +: 8]} : ram_rdata;

  data_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      read_data_reg <= '0;
      fault_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      byte_reg      <= 1'b0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          fault_reg <= 1'b0;
          if (req) begin
            addr_reg  <= addr;
            wdata_reg <= write_data;
            byte_reg  <= byte_acc;
            rd_reg    <= mem_read;
            wr_reg    <= mem_write;
            cnt_reg   <= CNT_W'(LATENCY);
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          // A withdrawn request aborts without touching RAM or raising fault.
          if (!req) begin
            state_reg <= IDLE;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            state_reg <= RESP;
            fault_reg <= (cause != FC_NONE);
            if (cause != FC_NONE) read_data_reg <= '0;
            else if (rd_reg)      read_data_reg <= lane_data;
          end
        end
        RESP: begin
          fault_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stall     = (state_reg == BUSY) || ((state_reg == IDLE) && req);
  assign read_data = read_data_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized bench for data_memory_responder: a LATENCY=2 and a LATENCY=0 instance share the bus
// and are checked against a word-array memory model with byte-lane rules.
module tb_data_memory_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, byte_acc;
  logic [31:0] addr, write_data;
  logic        use_fast;

  logic        rd_s, wr_s, rd_f, wr_f;
  logic [31:0] rdata_s, rdata_f;
  logic        stall_s, stall_f, fault_s, fault_f;
  logic [31:0] rdata_o;
  logic        stall_o, fault_o;

  assign rd_s = mem_read  & ~use_fast;
  assign wr_s = mem_write & ~use_fast;
  assign rd_f = mem_read  &  use_fast;
  assign wr_f = mem_write &  use_fast;

  assign rdata_o = use_fast ? rdata_f : rdata_s;
  assign stall_o = use_fast ? stall_f : stall_s;
  assign fault_o = use_fast ? fault_f : fault_s;

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_slow (
    .clk(clk), .reset(reset), .mem_read(rd_s), .mem_write(wr_s), .byte_acc(byte_acc),
    .addr(addr), .write_data(write_data), .read_data(rdata_s), .stall(stall_s), .fault(fault_s)
  );

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_fast (
    .clk(clk), .reset(reset), .mem_read(rd_f), .mem_write(wr_f), .byte_acc(byte_acc),
    .addr(addr), .write_data(write_data), .read_data(rdata_f), .stall(stall_f), .fault(fault_f)
  );

  always #5 clk = ~clk;

  logic [31:0] model_s [DEPTH];
  logic [31:0] model_f [DEPTH];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete CPU access; entered and left at #1 after a posedge with the DUT in IDLE.
  task automatic access(input bit fast, input bit rd, input bit wr, input bit bt,
                        input logic [31:0] a, input logic [31:0] wd);
    int          lat;
    int          n;
    int          idx;
    logic        exp_fault;
    logic [31:0] word;
    logic [31:0] exp_rd;
    lat       = fast ? 0 : 2;
    idx       = int'(a[9:2]);
    exp_fault = (rd && wr) || (!bt && a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    word      = fast ? model_f[idx] : model_s[idx];
    exp_rd    = 32'h0;
    if (!exp_fault && rd) exp_rd = bt ? ((word >> (8 * a[1:0])) & 32'hFF) : word;

    use_fast = fast; mem_read = rd; mem_write = wr; byte_acc = bt; addr = a; write_data = wd;
    #1;
    check("accept_stall", {31'b0, stall_o}, 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      if (stall_o) n++;
    end while (stall_o && n < 20);
    check("stall_cycles", 32'(n), 32'(lat + 1));
    check("fault", {31'b0, fault_o}, {31'b0, exp_fault});
    if (rd || exp_fault) check("read_data", rdata_o, exp_rd);
    $display("lat=%0d rd=%0d wr=%0d byte=%0d addr=%h wd=%h -> rdata=%h fault=%0d stall_cycles=%0d",
             lat, rd, wr, bt, a, wd, rdata_o, fault_o, n);

    if (wr && !exp_fault) begin
      if (bt) word[8 * a[1:0] +: 8] = wd[7:0];
      else    word = wd;
      if (fast) model_f[idx] = word;
      else      model_s[idx] = word;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit          fast, rd, wr, bt;
    logic [31:0] a;
    int          r;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; byte_acc = 1'b0;
    addr = '0; write_data = '0; use_fast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall_s", {31'b0, stall_s}, 32'd0);
    check("rst_fault_s", {31'b0, fault_s}, 32'd0);
    check("rst_rdata_s", rdata_s, 32'd0);
    check("rst_stall_f", {31'b0, stall_f}, 32'd0);
    check("rst_rdata_f", rdata_f, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Give every word a known value in both memories.
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom);
      access(1'b1, 1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom);
    end

    // Word store then load.
    access(1'b0, 1'b0, 1'b1, 1'b0, 32'd32, 32'h0000000F);
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'd32, 32'h0);
    check("t1_load", rdata_o, 32'h0000000F);

    // Byte store into a word, then word and byte loads.
    access(1'b0, 1'b0, 1'b1, 1'b0, 32'd32, 32'h11223344);
    access(1'b0, 1'b0, 1'b1, 1'b1, 32'd33, 32'hFFFFFFAB);
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'd32, 32'h0);
    check("t2_word", rdata_o, 32'h1122AB44);
    access(1'b0, 1'b1, 1'b0, 1'b1, 32'd35, 32'h0);
    check("t2_byte", rdata_o, 32'h00000011);

    // Misaligned, out-of-range and read+write faults leave memory untouched.
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'd34, 32'h0);
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'(DEPTH * 4), 32'h0);
    access(1'b0, 1'b0, 1'b1, 1'b0, 32'(DEPTH * 4 + 8), 32'hCAFEF00D);
    access(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h55555555);
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'd32, 32'h0);

    // Store withdrawn after one BUSY cycle.
    use_fast = 1'b0; mem_write = 1'b1; byte_acc = 1'b0; addr = 32'd64; write_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("abort_busy_stall", {31'b0, stall_s}, 32'd1);
    mem_write = 1'b0;
    @(posedge clk); #1;
    check("abort_stall", {31'b0, stall_s}, 32'd0);
    check("abort_fault", {31'b0, fault_s}, 32'd0);
    @(posedge clk); #1;
    check("abort_fault2", {31'b0, fault_s}, 32'd0);
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'd64, 32'h0);

    // Reset while a store is waiting.
    mem_write = 1'b1; addr = 32'd68; write_data = 32'h0BADF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    check("rst_busy_stall", {31'b0, stall_s}, 32'd0);
    check("rst_busy_fault", {31'b0, fault_s}, 32'd0);
    reset = 1'b0;
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'd68, 32'h0);

    // Zero-wait-state store/load pair and back-to-back loads.
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'd128, 32'h89ABCDEF);
    access(1'b1, 1'b1, 1'b0, 1'b0, 32'd128, 32'h0);
    access(1'b1, 1'b1, 1'b0, 1'b1, 32'd130, 32'h0);
    access(1'b1, 1'b1, 1'b0, 1'b0, 32'd32, 32'h0);

    for (int i = 0; i < 300; i++) begin
      fast = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 15));
      rd   = (r < 7) || (r == 15);
      wr   = (r >= 7);
      bt   = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 15));
      if (r == 0)      a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
      else if (r == 1) a = $urandom;
      else             a = 32'($urandom_range(0, DEPTH * 4 - 1));
      if (!bt && r != 2) a[1:0] = 2'b00;
      if (!bt && r == 2) a[0] = 1'b1;
      access(fast, rd, wr, bt, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
